rr_decoder_arbiter: RTL and testbench

- 8-requester round-robin arbiter that shares the 3-to-8 decoder resource.
- Picks one requester and registers its 3-bit index; the one-hot grant vector is that index decoded 3-to-8 (D[i] = 1 for index i).
- Holds the grant while the winner keeps requesting, then rotates priority.
- Sits between requesting blocks and any shared resource selected through a decoded enable.

---
 rtl/rr_decoder_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Eight-way round-robin arbiter whose grant is the registered winner index decoded 3-to-8.
// Define ARB_HOLD_LIMIT_EN to enable a MAX_HOLD-cycle hold limit with forced rotation.
module rr_decoder_arbiter #(
    parameter int N_REQ = 8
`ifdef ARB_HOLD_LIMIT_EN
    ,
    parameter int MAX_HOLD = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptrNext;
    logic [2:0]       r_gntIdx;
    logic [2:0]       w_idxNext;
    logic             r_gntValid;
    logic             w_validNext;
    logic [N_REQ-1:0] r_gnt;
    logic [2:0]       w_searchBase;
    logic [2:0]       w_winIdx;
    logic             w_winFound;
    logic             w_forceRelease;

    // A release searches from just past the current winner, so that winner ends up lowest priority.
    assign w_searchBase = (r_state == GRANT) ? r_gntIdx + 3'd1 : r_ptr;

    always_comb begin
        w_winFound = 1'b0;
        w_winIdx   = w_searchBase;
        for (int k = 0; k < 8; k++) begin
            if (!w_winFound && req[w_searchBase + 3'(k)]) begin
                w_winFound = 1'b1;
                w_winIdx   = w_searchBase + 3'(k);
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic [3:0] r_hold;
    logic [3:0] w_holdNext;
    logic [3:0] w_holdInc;
    logic       w_othersPending;

    assign w_holdInc       = (r_hold == HOLD_LIMIT) ? r_hold : r_hold + 4'd1;
    assign w_othersPending = |(req & ~(N_REQ'(1) << r_gntIdx));
    assign w_forceRelease  = (r_state == GRANT) && (w_holdInc == HOLD_LIMIT) && w_othersPending;

    // The counter only keeps running while the same winner stays granted.
    assign w_holdNext = (r_state == GRANT && w_stateNext == GRANT && w_idxNext == r_gntIdx)
                        ? w_holdInc : 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= 4'd0;
        end else begin
            r_hold <= w_holdNext;
        end
    end
`else
    assign w_forceRelease = 1'b0;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_idxNext   = r_gntIdx;
        w_validNext = r_gntValid;
        case (r_state)
            IDLE: begin
                if (w_winFound) begin
                    w_stateNext = GRANT;
                    w_idxNext   = w_winIdx;
                    w_validNext = 1'b1;
                end else begin
                    w_idxNext   = 3'd0;
                    w_validNext = 1'b0;
                end
            end
            GRANT: begin
                if (!req[r_gntIdx] || w_forceRelease) begin
                    w_ptrNext = r_gntIdx + 3'd1;
                    if (w_winFound) begin
                        w_stateNext = GRANT;
                        w_idxNext   = w_winIdx;
                        w_validNext = 1'b1;
                    end else begin
                        w_stateNext = IDLE;
                        w_idxNext   = 3'd0;
                        w_validNext = 1'b0;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_idxNext   = 3'd0;
                w_validNext = 1'b0;
            end
        endcase
    end

    // The decoded grant is registered alongside the index so the outputs can never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 3'd0;
            r_gntIdx   <= 3'd0;
            r_gntValid <= 1'b0;
            r_gnt      <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_ptr      <= w_ptrNext;
            r_gntIdx   <= w_idxNext;
            r_gntValid <= w_validNext;
            r_gnt      <= w_validNext ? (N_REQ'(1) << w_idxNext) : '0;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gntIdx;
    assign gnt_valid = r_gntValid;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: reset, rotation, wrap, hold, mid-grant reset and empty cases.
// Hold-phase expectations follow ARB_HOLD_LIMIT_EN when it is defined.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    rr_decoder_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the inputs, then return 1ns after the next rising edge so outputs are settled.
    task automatic applyStimulus(input logic [7:0] inReq, input logic inRstN);
        req   = inReq;
        rst_n = inRstN;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expGnt,
                               input logic [2:0] expIdx, input logic expValid);
        checks++;
        assert ({gnt, gnt_idx, gnt_valid} === {expGnt, expIdx, expValid})
        else begin
            failures++;
            $error("[TB] FAIL %s: observed gnt=%02h idx=%0d valid=%0b expected gnt=%02h idx=%0d valid=%0b",
                   tag, gnt, gnt_idx, gnt_valid, expGnt, expIdx, expValid);
        end
    endtask

    initial begin
        logic [7:0] dropMask;
        logic [2:0] expIdx;
        logic [7:0] expGnt;
        int         holdCycles;

        req   = 8'hFF;
        rst_n = 1'b0;

        applyStimulus(8'hFF, 1'b0);
        checkOutput("reset_1", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("reset_2", 8'h00, 3'd0, 1'b0);

        applyStimulus(8'hFF, 1'b1);
        checkOutput("first_grant", 8'h01, 3'd0, 1'b1);

        for (int k = 1; k <= 8; k++) begin
            dropMask = 8'h01 << (k - 1);
            applyStimulus(~dropMask, 1'b1);
            expIdx = 3'(k % 8);
            expGnt = 8'h01 << expIdx;
            checkOutput($sformatf("rotate_%0d", k), expGnt, expIdx, 1'b1);
        end

        applyStimulus(8'h20, 1'b1);
        checkOutput("grant_idx5", 8'h20, 3'd5, 1'b1);
        applyStimulus(8'h03, 1'b1);
        checkOutput("wrap_to_idx0", 8'h01, 3'd0, 1'b1);
        applyStimulus(8'h80, 1'b1);
        checkOutput("grant_idx7", 8'h80, 3'd7, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("idx7_to_idle", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h80, 1'b1);
        checkOutput("regrant_idx7", 8'h80, 3'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h80, 1'b1);
            checkOutput($sformatf("hold_idx7_%0d", k), 8'h80, 3'd7, 1'b1);
        end

        applyStimulus(8'h08, 1'b1);
        checkOutput("grant_idx3", 8'h08, 3'd3, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
        holdCycles = 4;
`else
        holdCycles = 20;
`endif
        for (int c = 0; c < holdCycles; c++) begin
            applyStimulus((c >= 2) ? 8'h0C : 8'h08, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
            if (c < 3) checkOutput($sformatf("hold_%0d", c), 8'h08, 3'd3, 1'b1);
            else       checkOutput($sformatf("hold_%0d", c), 8'h04, 3'd2, 1'b1);
`else
            checkOutput($sformatf("hold_%0d", c), 8'h08, 3'd3, 1'b1);
`endif
        end

        applyStimulus(8'h08, 1'b1);
        checkOutput("idx3_before_reset", 8'h08, 3'd3, 1'b1);
        applyStimulus(8'h08, 1'b0);
        checkOutput("mid_grant_reset", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h08, 1'b1);
        checkOutput("after_reset_idx3", 8'h08, 3'd3, 1'b1);

        applyStimulus(8'h04, 1'b1);
        checkOutput("grant_idx2", 8'h04, 3'd2, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("empty_release", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h0C, 1'b1);
        checkOutput("ptr3_picks_idx3", 8'h08, 3'd3, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("final_idle", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("idle_stays", 8'h00, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
